// File: rtl/spi_master.sv
// Memory-mapped single-byte SPI mode-0 master: software drives chip select, loads TX_DATA,
// starts a transfer, polls STATUS and collects RX_DATA. The SCK half-period comes from CLK_DIV.
module spi_master #(
   parameter logic [7:0] DEFAULT_DIV = 8'd4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        spi_ss_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam logic [7:0] ADDR_STATUS  = 8'h00;
   localparam logic [7:0] ADDR_SS_EN   = 8'h08;
   localparam logic [7:0] ADDR_TX      = 8'h09;
   localparam logic [7:0] ADDR_START   = 8'h0a;
   localparam logic [7:0] ADDR_RX      = 8'h0b;
   localparam logic [7:0] ADDR_CLK_DIV = 8'h0c;

   typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

   state_t      state_r;
   logic        ss_en_r;
   logic [7:0]  tx_data_r;
   logic [7:0]  rx_data_r;
   logic        rx_valid_r;
   logic [7:0]  clk_div_r;
   logic [7:0]  cnt_r;
   logic [2:0]  bit_cnt_r;
   logic [7:0]  shift_r;

   logic        idle_s;
   logic        wr_idle_s;
   logic        rd_rx_s;
   logic [7:0]  div_eff_s;
   logic        unused_s;

   assign idle_s    = (state_r == ST_IDLE);
   assign wr_idle_s = cs & we & idle_s;
   assign rd_rx_s   = cs & ~we & (address == ADDR_RX);
   assign ready     = cs;
   assign unused_s  = ^write_data[31:8];

   // Divider of zero is treated as one so SCK never stalls.
   always_comb begin
      if (clk_div_r == 8'd0) begin
         div_eff_s = 8'd1;
      end else begin
         div_eff_s = clk_div_r;
      end
   end

   // Register read mux; non-selected and write-only addresses return zero.
   always_comb begin
      read_data = 32'h0;
      if (cs && !we) begin
         case (address)
            ADDR_STATUS:  read_data = {30'h0, rx_valid_r, idle_s};
            ADDR_SS_EN:   read_data = {31'h0, ss_en_r};
            ADDR_TX:      read_data = {24'h0, tx_data_r};
            ADDR_RX:      read_data = {24'h0, rx_data_r};
            ADDR_CLK_DIV: read_data = {24'h0, clk_div_r};
            default:      read_data = 32'h0;
         endcase
      end else begin
         read_data = 32'h0;
      end
   end

   // Control registers and the transfer FSM. MISO is shifted in at the SCK rising edge,
   // which moves the next TX bit into shift_r[7] ready for the following falling edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         ss_en_r    <= 1'b0;
         tx_data_r  <= 8'h00;
         rx_data_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         clk_div_r  <= DEFAULT_DIV;
         cnt_r      <= 8'h00;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         spi_ss_n   <= 1'b1;
         spi_sck    <= 1'b0;
         spi_mosi   <= 1'b0;
      end else begin
         if (rd_rx_s) begin
            rx_valid_r <= 1'b0;
         end
         if (wr_idle_s) begin
            case (address)
               ADDR_SS_EN: begin
                  ss_en_r  <= write_data[0];
                  spi_ss_n <= ~write_data[0];
               end
               ADDR_TX:      tx_data_r <= write_data[7:0];
               ADDR_CLK_DIV: clk_div_r <= write_data[7:0];
               default: ;
            endcase
         end
         case (state_r)
            ST_IDLE: begin
               if (wr_idle_s && (address == ADDR_START)) begin
                  shift_r   <= tx_data_r;
                  cnt_r     <= div_eff_s - 8'd1;
                  bit_cnt_r <= 3'd7;
                  spi_mosi  <= tx_data_r[7];
                  state_r   <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (cnt_r == 8'd0) begin
                  cnt_r   <= div_eff_s - 8'd1;
                  spi_sck <= 1'b1;
                  shift_r <= {shift_r[6:0], spi_miso};
                  state_r <= ST_HIGH;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            ST_HIGH: begin
               if (cnt_r == 8'd0) begin
                  cnt_r   <= div_eff_s - 8'd1;
                  spi_sck <= 1'b0;
                  if (bit_cnt_r != 3'd0) begin
                     spi_mosi  <= shift_r[7];
                     bit_cnt_r <= bit_cnt_r - 3'd1;
                     state_r   <= ST_LOW;
                  end else begin
                     state_r <= ST_DONE;
                  end
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            ST_DONE: begin
               rx_data_r  <= shift_r;
               rx_valid_r <= 1'b1;
               state_r    <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule
